jedro_1_sig_dumper: RTL and testbench

JEDRO_1_SIG_DUMPER -- requirements
Module: jedro_1_sig_dumper

---
 rtl/jedro_1_tb_pkg.sv | 16 +
 rtl/jedro_1_mailbox_snoop.sv | 58 +++++
 rtl/jedro_1_sig_dumper.sv | 146 ++++++++++++++
 tb/tb_jedro_1_sig_dumper.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_tb_pkg.sv
// Shared types and default mailbox addresses for the signature dumper.
package jedro_1_tb_pkg;

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [31:0] DEF_SIG_BEGIN_ADDR = 32'h001F_FFFC;
  localparam logic [31:0] DEF_SIG_END_ADDR   = 32'h001F_FFF8;
  localparam logic [31:0] DEF_HALT_ADDR      = 32'h001F_FFF4;

endpackage

// File: rtl/jedro_1_mailbox_snoop.sv
// Watches the data bus for full-word writes to the signature/halt mailboxes
// and keeps the latched begin/end/halt-code values.
module jedro_1_mailbox_snoop
  import jedro_1_tb_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH     = 32,
  parameter int unsigned             ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]   SIG_BEGIN_ADDR = ADDR_WIDTH'(DEF_SIG_BEGIN_ADDR),
  parameter logic [ADDR_WIDTH-1:0]   SIG_END_ADDR   = ADDR_WIDTH'(DEF_SIG_END_ADDR),
  parameter logic [ADDR_WIDTH-1:0]   HALT_ADDR      = ADDR_WIDTH'(DEF_HALT_ADDR)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    en_i,
  input  logic                    snp_stb_i,
  input  logic [DATA_WIDTH/8-1:0] snp_we_i,
  input  logic [ADDR_WIDTH-1:0]   snp_addr_i,
  input  logic [DATA_WIDTH-1:0]   snp_wdata_i,
  output logic [DATA_WIDTH-1:0]   sig_begin_o,
  output logic [DATA_WIDTH-1:0]   sig_end_o,
  output logic [DATA_WIDTH-1:0]   halt_code_o,
  output logic                    halt_o
);

  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(DATA_WIDTH/8 - 1);

  logic full_wr;
  logic hit_begin;
  logic hit_end;
  logic hit_halt;

  // Word-granular match: byte-offset bits within the word are ignored.
  function automatic logic word_hit(input logic [ADDR_WIDTH-1:0] a,
                                    input logic [ADDR_WIDTH-1:0] m);
    return ((a ^ m) & ~LOW_MASK) == '0;
  endfunction

  always_comb begin
    full_wr   = en_i && snp_stb_i && (&snp_we_i);
    hit_begin = full_wr && word_hit(snp_addr_i, SIG_BEGIN_ADDR);
    hit_end   = full_wr && word_hit(snp_addr_i, SIG_END_ADDR);
    hit_halt  = full_wr && word_hit(snp_addr_i, HALT_ADDR);
    halt_o    = hit_halt && (snp_wdata_i != '0);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sig_begin_o <= '0;
      sig_end_o   <= '0;
      halt_code_o <= '0;
    end else begin
      if (hit_begin) sig_begin_o <= snp_wdata_i;
      if (hit_end)   sig_end_o   <= snp_wdata_i;
      if (halt_o)    halt_code_o <= snp_wdata_i;
    end
  end

endmodule

// File: rtl/jedro_1_sig_dumper.sv
// Runs until a halt mailbox write or timeout, then reads the signature region
// from memory word by word and streams it out with valid/ready.
module jedro_1_sig_dumper
  import jedro_1_tb_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH     = 32,
  parameter int unsigned             ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]   SIG_BEGIN_ADDR = ADDR_WIDTH'(DEF_SIG_BEGIN_ADDR),
  parameter logic [ADDR_WIDTH-1:0]   SIG_END_ADDR   = ADDR_WIDTH'(DEF_SIG_END_ADDR),
  parameter logic [ADDR_WIDTH-1:0]   HALT_ADDR      = ADDR_WIDTH'(DEF_HALT_ADDR),
  parameter int unsigned             TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    snp_stb_i,
  input  logic [DATA_WIDTH/8-1:0] snp_we_i,
  input  logic [ADDR_WIDTH-1:0]   snp_addr_i,
  input  logic [DATA_WIDTH-1:0]   snp_wdata_i,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    sig_valid_o,
  input  logic                    sig_ready_i,
  output logic [DATA_WIDTH-1:0]   sig_data_o,
  output logic                    sig_last_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic [DATA_WIDTH-1:0]   halt_code_o
);

  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(DATA_WIDTH/8);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(DATA_WIDTH/8 - 1);
  localparam logic [31:0]           TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic [31:0]             cnt;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [DATA_WIDTH-1:0]   sig_begin;
  logic [DATA_WIDTH-1:0]   sig_end;
  logic                    halt;
  logic [ADDR_WIDTH-1:0]   begin_a;
  logic [ADDR_WIDTH-1:0]   end_a;
  logic [ADDR_WIDTH-1:0]   ptr_next;
  logic                    is_last;

  jedro_1_mailbox_snoop #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .SIG_BEGIN_ADDR (SIG_BEGIN_ADDR),
    .SIG_END_ADDR   (SIG_END_ADDR),
    .HALT_ADDR      (HALT_ADDR)
  ) u_snoop (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .en_i        (state == ST_RUN),
    .snp_stb_i   (snp_stb_i),
    .snp_we_i    (snp_we_i),
    .snp_addr_i  (snp_addr_i),
    .snp_wdata_i (snp_wdata_i),
    .sig_begin_o (sig_begin),
    .sig_end_o   (sig_end),
    .halt_code_o (halt_code_o),
    .halt_o      (halt)
  );

  // Last-word test uses one extra bit so a pointer near the top of the
  // address space still terminates instead of wrapping past the end.
  always_comb begin
    begin_a  = ADDR_WIDTH'(sig_begin);
    end_a    = ADDR_WIDTH'(sig_end);
    ptr_next = ptr + STEP;
    is_last  = ({1'b0, ptr} + {1'b0, STEP}) >= {1'b0, end_a};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ST_RUN;
      cnt         <= '0;
      ptr         <= '0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      sig_valid_o <= 1'b0;
      sig_data_o  <= '0;
      sig_last_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt) begin
            if (begin_a >= end_a) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state      <= ST_READ;
              ptr        <= begin_a & ~LOW_MASK;
              mem_req_o  <= 1'b1;
              mem_addr_o <= begin_a & ~LOW_MASK;
              busy_o     <= 1'b1;
            end
          end else if (cnt == TO_LAST) begin
            state     <= ST_DONE;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_READ: begin
          mem_req_o <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid_i) begin
            sig_data_o  <= mem_rdata_i;
            sig_valid_o <= 1'b1;
            sig_last_o  <= is_last;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (sig_ready_i) begin
            sig_valid_o <= 1'b0;
            sig_last_o  <= 1'b0;
            ptr         <= ptr_next;
            if (sig_last_o) begin
              state  <= ST_DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state      <= ST_READ;
              mem_req_o  <= 1'b1;
              mem_addr_o <= ptr_next;
            end
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_sig_dumper.sv
// Scoreboard bench for jedro_1_sig_dumper: random dumps checked against a
// word-list model of the signature region.
module tb_jedro_1_sig_dumper;

  localparam logic [31:0] A_BEGIN = 32'h001F_FFFC;
  localparam logic [31:0] A_END   = 32'h001F_FFF8;
  localparam logic [31:0] A_HALT  = 32'h001F_FFF4;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        snp_stb = 1'b0;
  logic [3:0]  snp_we = '0;
  logic [31:0] snp_addr = '0;
  logic [31:0] snp_wdata = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        sig_valid;
  logic        sig_ready = 1'b0;
  logic [31:0] sig_data;
  logic        sig_last;
  logic        busy, done, timeout;
  logic [31:0] halt_code;

  int          checks = 0;
  int          failures = 0;
  int          beats = 0;
  int          ready_mode = 0;
  int          mem_delay = 0;
  int          rtick = 0;
  beat_t       exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  jedro_1_sig_dumper #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .snp_stb_i    (snp_stb),
    .snp_we_i     (snp_we),
    .snp_addr_i   (snp_addr),
    .snp_wdata_i  (snp_wdata),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .sig_valid_o  (sig_valid),
    .sig_ready_i  (sig_ready),
    .sig_data_o   (sig_data),
    .sig_last_o   (sig_last),
    .busy_o       (busy),
    .done_o       (done),
    .timeout_o    (timeout),
    .halt_code_o  (halt_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Ready driver: 0 always ready, 1 ready one cycle in three, 2 random, 3 ready for first beat only
  always @(posedge clk) begin
    #1;
    rtick++;
    case (ready_mode)
      0: sig_ready = 1'b1;
      1: sig_ready = (rtick % 3 == 0);
      2: sig_ready = $urandom_range(0, 1) == 1;
      default: sig_ready = (beats == 0);
    endcase
  end

  // Memory responder with programmable read latency
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (rstn && mem_req) begin
        a = mem_addr;
        @(posedge clk);
        repeat (mem_delay) @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability
  always @(negedge clk) begin
    if (rstn && sig_valid) begin
      if (prev_stall) check("stall_stable", sig_data, prev_data);
      if (sig_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", sig_data, 32'h0);
          checks++;
          failures++;
          $display("FAIL unexpected_beat: beat with data 0x%08h but none expected", sig_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", sig_data, e.data);
          check("beat_last", {31'b0, sig_last}, {31'b0, e.last});
        end
      end
      prev_stall = !sig_ready;
      prev_data  = sig_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    snp_stb = 1'b0;
    snp_we = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    beats = 0;
  endtask

  task automatic snp_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    @(negedge clk);
    snp_stb   = 1'b1;
    snp_we    = we;
    snp_addr  = addr;
    snp_wdata = data;
    @(posedge clk);
    #1;
    snp_stb = 1'b0;
    snp_we  = '0;
  endtask

  // Reference model: whole words from aligned begin while below end
  task automatic expect_dump(input logic [31:0] b, input logic [31:0] e);
    logic [32:0] a;
    beat_t       x;
    if (b >= e) return;
    a = {1'b0, b & 32'hFFFF_FFFC};
    while (a < {1'b0, e}) begin
      if (!mem.exists(a[31:0])) mem[a[31:0]] = $urandom;
      x.data = mem[a[31:0]];
      x.last = (a + 33'd4) >= {1'b0, e};
      exp_q.push_back(x);
      a = a + 33'd4;
    end
  endtask

  task automatic wait_done(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_reached", {31'b0, done}, 32'h1);
  endtask

  task automatic run_dump(input string tag, input logic [31:0] b, input logic [31:0] e,
                          input logic [31:0] hc);
    int nexp;
    snp_write(A_BEGIN | 32'($urandom_range(0, 3)), b, 4'hF);
    snp_write(A_END, e, 4'hF);
    expect_dump(b, e);
    nexp = exp_q.size();
    snp_write(A_HALT, hc, 4'hF);
    wait_done(2000);
    check({tag, "_beats"}, 32'(beats), 32'(nexp));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
    check({tag, "_halt_code"}, halt_code, hc);
    check({tag, "_timeout"}, {31'b0, timeout}, 32'h0);
    check({tag, "_busy"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    int cyc;
    int i;
    logic [31:0] b;
    logic [31:0] e;

    // Reset state
    rstn = 1'b0;
    #12;
    check("rst_valid", {31'b0, sig_valid}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_memreq", {31'b0, mem_req}, 32'h0);
    check("rst_halt_code", halt_code, 32'h0);

    // Basic four-word dump
    do_reset();
    ready_mode = 0;
    mem_delay  = 0;
    for (i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA + 32'(i);
    run_dump("basic", 32'h100, 32'h110, 32'h1);
    check("basic_done", {31'b0, done}, 32'h1);
    snp_write(A_HALT, 32'h77, 4'hF);
    repeat (2) @(negedge clk);
    check("post_done_halt_ignored", halt_code, 32'h1);
    check("done_sticky", {31'b0, done}, 32'h1);

    // Back-pressure and slow memory
    do_reset();
    ready_mode = 1;
    mem_delay  = 3;
    run_dump("stall", 32'h100, 32'h110, 32'h1);

    // Timeout with no halt
    do_reset();
    ready_mode = 0;
    mem_delay  = 0;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) break;
    end
    check("timeout_cycle", 32'(cyc), 32'd50);
    check("timeout_flag", {31'b0, timeout}, 32'h1);
    check("timeout_beats", 32'(beats), 32'h0);

    // Partial and zero halt writes ignored, then empty dump
    do_reset();
    snp_write(A_HALT, 32'h9, 4'b0011);
    snp_write(A_HALT, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    check("partial_no_halt_busy", {31'b0, busy}, 32'h0);
    check("partial_no_halt_done", {31'b0, done}, 32'h0);
    check("partial_no_halt_code", halt_code, 32'h0);
    run_dump("empty", 32'h200, 32'h200, 32'h5);
    check("empty_done", {31'b0, done}, 32'h1);

    // Reset while the second beat is stalled
    do_reset();
    ready_mode = 3;
    mem_delay  = 1;
    snp_write(A_BEGIN, 32'h100, 4'hF);
    snp_write(A_END, 32'h110, 4'hF);
    expect_dump(32'h100, 32'h110);
    snp_write(A_HALT, 32'h3, 4'hF);
    cyc = 0;
    while (cyc < 200 && !(beats == 1 && sig_valid)) begin
      @(negedge clk);
      cyc++;
    end
    check("second_beat_seen", {31'b0, sig_valid}, 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_valid", {31'b0, sig_valid}, 32'h0);
    check("abort_data", sig_data, 32'h0);
    check("abort_last", {31'b0, sig_last}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_memreq", {31'b0, mem_req}, 32'h0);
    check("abort_halt_code", halt_code, 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    beats = 0;
    repeat (3) @(negedge clk);
    check("after_abort_beats", 32'(beats), 32'h0);
    check("after_abort_done", {31'b0, done}, 32'h0);
    ready_mode = 0;
    run_dump("after_abort", 32'h180, 32'h188, 32'h2);

    // Randomized dumps
    for (int t = 0; t < 8; t++) begin
      do_reset();
      ready_mode = 2 * $urandom_range(0, 1);
      mem_delay  = $urandom_range(0, 3);
      b = 32'h400 + 32'($urandom_range(0, 63));
      e = b + 32'($urandom_range(0, 24));
      run_dump("rand", b, e, 32'($urandom_range(1, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
